// File: rtl/pcap_replay_pkg.sv
// Shared definitions for the PCAP replay inter-packet-gap shaper.
//   - state_e          : pacing FSM states (IDLE / XFER / GAP)
//   - TUSER_DELAY_*    : bit positions of the per-packet gap override in tuser
//   - DEF_*            : default stream, sideband and counter widths
package pcap_replay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned TUSER_DELAY_LSB = 96;
  localparam int unsigned TUSER_DELAY_MSB = 127;

  localparam int unsigned DEF_DATA_WIDTH  = 256;
  localparam int unsigned DEF_TUSER_WIDTH = 128;
  localparam int unsigned DEF_DELAY_WIDTH = 32;
  localparam int unsigned PKT_COUNT_WIDTH = 32;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream skid buffer with a registered upstream ready.
// The payload is an opaque WIDTH-bit word (data+strb+user+last packed by
// the caller). Accepted words appear on m_* the following cycle, full
// throughput is sustained while m_ready stays high, and m_* hold stable
// while stalled.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr             synchronous clear, drops any buffered words
//   s_data/s_valid  upstream word / valid;  s_ready upstream accept
//   m_data/m_valid  downstream word / valid; m_ready downstream accept
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 417
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] out_q, out_d, skid_q, skid_d;
  logic             out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic             rdy_q, rdy_d;
  logic             in_fire;

  assign in_fire = s_valid && rdy_q;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (clr) begin
      out_d      = '0;
      out_vld_d  = 1'b0;
      skid_d     = '0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || m_ready) begin
      // Output register free: drain the skid slot first to keep order.
      // rdy_q is low whenever the skid slot is full, so no new word can
      // arrive in the same cycle.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = in_fire;
        if (in_fire) out_d = s_data;
      end
    end else if (in_fire) begin
      // Output stalled: park the word that was accepted on ready.
      skid_d     = s_data;
      skid_vld_d = 1'b1;
    end
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign s_ready = rdy_q;
  assign m_data  = out_q;
  assign m_valid = out_vld_q;

endmodule

// File: rtl/pcap_replay_ipg_shaper.sv
// Inter-packet-gap shaper for the PCAP replay engine. Packets pass through
// unmodified via a two-entry skid buffer; after each packet's last beat is
// accepted, upstream ready is held low for ipg_delay cycles (when enable=1).
// Optional feature macro: PCAP_REPLAY_TUSER_DELAY_EN -- a nonzero
// tuser[127:96] on a packet's first beat overrides ipg_delay for that gap.
// Ports:
//   axi_aclk, axi_areset          clock, asynchronous active-high reset
//   s_axis_*                      packets from the replay engine
//   m_axis_*                      paced packets to the datapath
//   sw_rst                        synchronous soft reset (state, counters, buffer)
//   enable                        pacing enable; 0 = pass-through
//   ipg_delay                     idle cycles inserted after each packet
//   pkt_count                     packets emitted on m_axis (wraps)
//   gap_active                    high while the gap is being enforced
module pcap_replay_ipg_shaper
  import pcap_replay_pkg::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int unsigned DELAY_WIDTH          = DEF_DELAY_WIDTH
) (
  input  logic                              axi_aclk,
  input  logic                              axi_areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  input  logic                              sw_rst,
  input  logic                              enable,
  input  logic [DELAY_WIDTH-1:0]            ipg_delay,
  output logic [PKT_COUNT_WIDTH-1:0]        pkt_count,
  output logic                              gap_active
);

  if (C_M_AXIS_DATA_WIDTH != C_S_AXIS_DATA_WIDTH ||
      C_M_AXIS_TUSER_WIDTH != C_S_AXIS_TUSER_WIDTH) begin : g_width_check
    $error("pcap_replay_ipg_shaper: master and slave widths must match");
  end

  localparam int unsigned BUF_W = C_S_AXIS_DATA_WIDTH + C_S_AXIS_DATA_WIDTH/8
                                + C_S_AXIS_TUSER_WIDTH + 1;

  state_e                     state_q, state_d;
  logic [DELAY_WIDTH-1:0]     gap_cnt_q, gap_cnt_d;
  logic [PKT_COUNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic [DELAY_WIDTH-1:0]     gap_len;
  logic                       buf_ready, s_accept, m_accept, gap_start;
  logic [BUF_W-1:0]           buf_m_data;

  assign s_axis_tready = (state_q != ST_GAP) && buf_ready;
  assign s_accept      = s_axis_tvalid && s_axis_tready;
  assign m_accept      = m_axis_tvalid && m_axis_tready;

`ifdef PCAP_REPLAY_TUSER_DELAY_EN
  logic [DELAY_WIDTH-1:0] pkt_delay_q, pkt_delay_d, beat_delay, tuser_delay;

  assign beat_delay = DELAY_WIDTH'(s_axis_tuser[TUSER_DELAY_MSB:TUSER_DELAY_LSB]);
  // In IDLE the beat being accepted is the packet's first beat; later
  // beats use the value captured from that first beat.
  assign tuser_delay = (state_q == ST_IDLE) ? beat_delay : pkt_delay_q;
  assign gap_len     = (tuser_delay != '0) ? tuser_delay : ipg_delay;

  always_comb begin
    pkt_delay_d = pkt_delay_q;
    if (sw_rst)                                pkt_delay_d = '0;
    else if (s_accept && state_q == ST_IDLE)   pkt_delay_d = beat_delay;
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) pkt_delay_q <= '0;
    else            pkt_delay_q <= pkt_delay_d;
  end
`else
  assign gap_len = ipg_delay;
`endif

  assign gap_start = enable && (gap_len != '0);

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    if (sw_rst) begin
      state_d   = ST_IDLE;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_XFER: begin
          if (s_accept) begin
            if (!s_axis_tlast) begin
              state_d = ST_XFER;
            end else if (gap_start) begin
              // Gap length is frozen here; later ipg_delay writes wait
              // for the next packet.
              state_d   = ST_GAP;
              gap_cnt_d = gap_len;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (!enable || gap_cnt_q == DELAY_WIDTH'(1)) begin
            state_d   = ST_IDLE;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q - DELAY_WIDTH'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (sw_rst)                     pkt_count_d = '0;
    else if (m_accept && m_axis_tlast) pkt_count_d = pkt_count_q + PKT_COUNT_WIDTH'(1);
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  axis_skid_buffer #(
    .WIDTH (BUF_W)
  ) u_skid (
    .clk     (axi_aclk),
    .rst     (axi_areset),
    .clr     (sw_rst),
    .s_data  ({s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata}),
    .s_valid (s_axis_tvalid && (state_q != ST_GAP)),
    .s_ready (buf_ready),
    .m_data  (buf_m_data),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = buf_m_data;
  assign pkt_count  = pkt_count_q;
  assign gap_active = (state_q == ST_GAP);

endmodule

// File: tb/tb_pcap_replay_ipg_shaper.sv
// Scoreboard bench for pcap_replay_ipg_shaper: stimulus pushes expected
// beats and expected gap lengths; a forked monitor pops and compares.
module tb_pcap_replay_ipg_shaper;
  localparam int DW  = 256;
  localparam int SW  = 32;
  localparam int UW  = 128;
  localparam int DLW = 32;
  typedef logic [DW+SW+UW:0] beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0]  s_axis_tdata = '0;
  logic [SW-1:0]  s_axis_tstrb = '0;
  logic [UW-1:0]  s_axis_tuser = '0;
  logic           s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
  logic [DW-1:0]  m_axis_tdata;
  logic [SW-1:0]  m_axis_tstrb;
  logic [UW-1:0]  m_axis_tuser;
  logic           m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic           sw_rst = 1'b0, enable = 1'b0;
  logic [DLW-1:0] ipg_delay = '0;
  logic [31:0]    pkt_count;
  logic           gap_active;

  logic tog = 1'b0, toggle_en = 1'b0, rdy_fix = 1'b1;
  always @(posedge clk) tog <= ~tog;
  assign m_axis_tready = toggle_en ? tog : rdy_fix;

  pcap_replay_ipg_shaper dut (
    .axi_aclk(clk), .axi_areset(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .sw_rst(sw_rst), .enable(enable), .ipg_delay(ipg_delay),
    .pkt_count(pkt_count), .gap_active(gap_active)
  );

  int    n_tests = 0, n_fail = 0;
  beat_t exp_q[$];
  int    exp_gap_q[$];
  int    hs_cyc_q[$];
  int    cyc = 0, gap_len = 0;
  bit    mon_en = 1'b1, stall_q = 1'b0, gap_rdy_bad = 1'b0;
  beat_t hold;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic mon_step();
    beat_t act, e;
    int    eg;
    act = {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata};
    cyc++;
    if (mon_en) begin
      if (stall_q) begin
        n_tests++;
        if (m_axis_tvalid !== 1'b1 || act !== hold) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b got %h required %h", m_axis_tvalid, act, hold);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cyc_q.push_back(cyc);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got %h required none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL beat_data: got %h required %h", act, e);
          end
        end
      end
      stall_q = m_axis_tvalid && !m_axis_tready;
      hold    = act;
    end else begin
      stall_q = 1'b0;
    end
    if (gap_active) begin
      gap_len++;
      if (s_axis_tready) gap_rdy_bad = 1'b1;
    end else if (gap_len != 0) begin
      n_tests++;
      if (exp_gap_q.size() == 0) begin
        n_fail++;
        $display("FAIL gap_unexpected: got %0d cycles required none", gap_len);
      end else begin
        eg = exp_gap_q.pop_front();
        if (gap_len != eg || gap_rdy_bad) begin
          n_fail++;
          $display("FAIL gap_len: got %0d (tready_in_gap=%b) required %0d", gap_len, gap_rdy_bad, eg);
        end
      end
      gap_len     = 0;
      gap_rdy_bad = 1'b0;
    end
  endtask

  function automatic beat_t mk_beat(input int base, input int i, input int n, input logic [31:0] uhi);
    logic [31:0] w;
    w = 32'(base * 16 + i);
    return {(i == n - 1), (i == 0) ? uhi : 32'h0, {3{w}}, ~32'(i), {8{w}}};
  endfunction

  task automatic send_beat(input beat_t b, input bit push);
    int n;
    bit ok;
    s_axis_tdata  = b[DW-1:0];
    s_axis_tstrb  = b[DW+SW-1:DW];
    s_axis_tuser  = b[DW+SW+UW-1:DW+SW];
    s_axis_tlast  = b[DW+SW+UW];
    s_axis_tvalid = 1'b1;
    if (push) exp_q.push_back(b);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_axis_tvalid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no tready in %0d cycles required tready", n);
    end
  endtask

  task automatic send_pkt(input int base, input int n, input logic [31:0] uhi, input bit push);
    for (int i = 0; i < n; i++) send_beat(mk_beat(base, i, n, uhi), push);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tdata", |m_axis_tdata, 0);
    check("rst_m_tstrb_user_last", |{m_axis_tstrb, m_axis_tuser, m_axis_tlast}, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_gap_active", gap_active, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("tready_after_rst", s_axis_tready, 1);
    @(posedge clk); #1;

    // Two back-to-back 3-beat packets, 5-cycle gaps
    enable = 1'b1;
    ipg_delay = 5;
    hs_cyc_q.delete();
    exp_gap_q.push_back(5);
    exp_gap_q.push_back(5);
    send_pkt(1, 3, 32'h0, 1'b1);
    send_pkt(2, 3, 32'h0, 1'b1);
    wait_cyc(12);
    check("a_beats", hs_cyc_q.size(), 6);
    if (hs_cyc_q.size() == 6) begin
      check("a_throughput", hs_cyc_q[2] - hs_cyc_q[0], 2);
      check("a_pkt2_start", hs_cyc_q[3] - hs_cyc_q[2], 6);
    end
    check("a_pkt_count", pkt_count, 2);

    // Soft reset clears the counter
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    @(negedge clk);
    check("swrst_pkt_count", pkt_count, 0);
    @(posedge clk); #1;

    // Pass-through: ten one-beat packets, no gaps
    enable = 1'b0;
    ipg_delay = 100;
    hs_cyc_q.delete();
    for (int p = 0; p < 10; p++) send_pkt(16 + p, 1, 32'h0, 1'b1);
    wait_cyc(5);
    check("b_beats", hs_cyc_q.size(), 10);
    if (hs_cyc_q.size() == 10)
      for (int i = 1; i < 10; i++) check("b_one_per_cycle", hs_cyc_q[i] - hs_cyc_q[i-1], 1);
    check("b_pkt_count", pkt_count, 10);

    // Downstream ready toggling each cycle over a 4-beat packet
    toggle_en = 1'b1;
    send_pkt(40, 4, 32'h0, 1'b1);
    wait_cyc(15);
    toggle_en = 1'b0;
    rdy_fix = 1'b1;
    check("c_pkt_count", pkt_count, 11);

    // ipg_delay changed during a gap only affects the next gap
    enable = 1'b1;
    ipg_delay = 10;
    exp_gap_q.push_back(10);
    exp_gap_q.push_back(2);
    send_pkt(50, 1, 32'h0, 1'b1);
    wait_cyc(3);
    ipg_delay = 2;
    send_pkt(51, 1, 32'h0, 1'b1);
    wait_cyc(6);

    // enable dropping mid-gap ends the gap on the next cycle
    ipg_delay = 20;
    exp_gap_q.push_back(4);
    send_pkt(60, 1, 32'h0, 1'b1);
    wait_cyc(3);
    enable = 1'b0;
    wait_cyc(5);

    // tuser gap override: only honoured when the feature is built in
    enable = 1'b1;
    ipg_delay = 3;
`ifdef PCAP_REPLAY_TUSER_DELAY_EN
    exp_gap_q.push_back(7);
`else
    exp_gap_q.push_back(3);
`endif
    send_pkt(70, 1, 32'd7, 1'b1);
    wait_cyc(10);
    exp_gap_q.push_back(3);
    send_pkt(71, 1, 32'd0, 1'b1);
    wait_cyc(6);
    check("f_pkt_count", pkt_count, 16);

    // Soft reset with two beats buffered and downstream stalled
    enable = 1'b0;
    mon_en = 1'b0;
    rdy_fix = 1'b0;
    send_beat(mk_beat(80, 0, 4, 32'h0), 1'b0);
    send_beat(mk_beat(80, 1, 4, 32'h0), 1'b0);
    @(negedge clk);
    check("g_full_tready", s_axis_tready, 0);
    check("g_full_tvalid", m_axis_tvalid, 1);
    @(posedge clk); #1;
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    @(negedge clk);
    check("g_tvalid_cleared", m_axis_tvalid, 0);
    check("g_pkt_count", pkt_count, 0);
    check("g_gap_active", gap_active, 0);
    check("g_tready", s_axis_tready, 1);
    @(posedge clk); #1;
    rdy_fix = 1'b1;
    mon_en = 1'b1;
    send_pkt(90, 1, 32'h0, 1'b1);
    wait_cyc(5);
    check("g_pkt_count_after", pkt_count, 1);

    check("exp_beats_left", exp_q.size(), 0);
    check("exp_gaps_left", exp_gap_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
